// File: rtl/zigbee_iq_pkg.sv
// zigbee_iq_pkg
//   Shared constants and types for the ZigBee phase/IQ datapath, used by the
//   transmit-side phase-to-IQ converter, the CORDIC phase detector and the
//   benches of both.
//   - IQ_SIZE / W_SIZE / ACC_FRAC : sample width, phase width, fractional bits
//   - AMPLITUDE                   : peak |I|,|Q| (receive-side convention)
//   - iq_t / phase_t / acc_t      : signed sample, unsigned phase, accumulator
//   - COS_LUT[0:16]               : quarter-wave cosine, one entry per phase LSB
package zigbee_iq_pkg;

    localparam int IQ_SIZE   = 5;
    localparam int W_SIZE    = 6;
    localparam int ACC_FRAC  = 4;
    localparam int ACC_SIZE  = W_SIZE + ACC_FRAC;
    localparam int AMPLITUDE = 15;

    // 64 steps per turn.
    localparam real PHASE_LSB_DEG = 5.625;

    typedef logic signed [IQ_SIZE-1:0]  iq_t;
    typedef logic        [W_SIZE-1:0]   phase_t;
    typedef logic        [ACC_SIZE-1:0] acc_t;

    // round-half-away(AMPLITUDE * cos(k * 5.625 deg)), k = 0..16
    localparam iq_t COS_LUT [0:16] = '{
        5'sd15, 5'sd15, 5'sd15, 5'sd14, 5'sd14, 5'sd13, 5'sd12, 5'sd12,
        5'sd11, 5'sd10, 5'sd8,  5'sd7,  5'sd6,  5'sd4,  5'sd3,  5'sd1,
        5'sd0
    };

endpackage

// File: rtl/zigbee_quarter_fold.sv
// zigbee_quarter_fold
//   Combinational quarter-wave LUT plus quadrant fold: maps a 6-bit phase to
//   the signed (I, Q) pair AMPLITUDE*(cos, sin) of that phase.
//   Ports:
//     p : in  phase_t  phase, LSB = 5.625 deg
//     I : out iq_t     in-phase value
//     Q : out iq_t     quadrature value
module zigbee_quarter_fold
    import zigbee_iq_pkg::*;
(
    input  phase_t p,
    output iq_t    I,
    output iq_t    Q
);

    logic [1:0] quad_s;
    logic [3:0] k_s;
    iq_t        cos_k_s;   // C[k]
    iq_t        cos_c_s;   // C[16-k], i.e. the sine of the in-quadrant angle

    assign quad_s  = p[5:4];
    assign k_s     = p[3:0];
    assign cos_k_s = COS_LUT[{1'b0, k_s}];
    assign cos_c_s = COS_LUT[5'd16 - {1'b0, k_s}];

    // Fold the first-quadrant pair into the addressed quadrant; |C| <= 15 so
    // the negations cannot overflow the 5-bit signed range.
    always_comb begin
        I = 5'sd0;
        Q = 5'sd0;
        case (quad_s)
            2'd0: begin I =  cos_k_s; Q =  cos_c_s; end
            2'd1: begin I = -cos_c_s; Q =  cos_k_s; end
            2'd2: begin I = -cos_k_s; Q = -cos_c_s; end
            2'd3: begin I =  cos_c_s; Q = -cos_k_s; end
            default: begin I = 5'sd0; Q = 5'sd0; end
        endcase
    end

endmodule

// File: rtl/zigbee_phase_to_iq.sv
// zigbee_phase_to_iq
//   Phase accumulator with fractional bits followed by a registered
//   quarter-wave cosine lookup, producing baseband I/Q samples.
//   Ports:
//     Clk       : in  rising-edge clock
//     Rst_n     : in  synchronous active-low reset
//     En        : in  sample strobe, advances the accumulator by Dphase
//     LoadPhase : in  load absolute phase (wins over En)
//     PhaseIn   : in  [5:0] absolute phase, LSB = 5.625 deg
//     Dphase    : in  [9:0] signed increment, LSB = 5.625/16 deg
//     Ibb, Qbb  : out [4:0] signed I/Q sample
//     PhaseOut  : out [5:0] phase behind the current Ibb/Qbb
//     Valid     : out Ibb/Qbb/PhaseOut carry a new sample
//   Latency: En/LoadPhase at edge N updates the accumulator at N; the
//   matching sample appears after edge N+1.
module zigbee_phase_to_iq
    import zigbee_iq_pkg::*;
(
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         En,
    input  logic                         LoadPhase,
    input  logic [W_SIZE-1:0]            PhaseIn,
    input  logic [W_SIZE+ACC_FRAC-1:0]   Dphase,
    output logic signed [IQ_SIZE-1:0]    Ibb,
    output logic signed [IQ_SIZE-1:0]    Qbb,
    output logic [W_SIZE-1:0]            PhaseOut,
    output logic                         Valid
);

    acc_t   acc_r;
    logic   en_d_r;
    phase_t phase_s;
    iq_t    fold_i_s;
    iq_t    fold_q_s;

    // Integer phase is the truncated top of the accumulator.
    assign phase_s = acc_r[ACC_SIZE-1 -: W_SIZE];

    zigbee_quarter_fold u_fold (
        .p (phase_s),
        .I (fold_i_s),
        .Q (fold_q_s)
    );

    // Stage 0: phase accumulator; the 10-bit add wraps modulo 2^10, which is
    // identical to adding the sign-extended signed increment.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            acc_r  <= '0;
            en_d_r <= 1'b0;
        end else begin
            if (LoadPhase) begin
                acc_r <= {PhaseIn, {ACC_FRAC{1'b0}}};
            end else if (En) begin
                acc_r <= acc_r + Dphase;
            end else begin
                acc_r <= acc_r;
            end
            en_d_r <= En | LoadPhase;
        end
    end

    // Stage 1: output registers always follow the accumulator; Valid marks
    // samples whose accumulator value was produced by En or LoadPhase.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Ibb      <= '0;
            Qbb      <= '0;
            PhaseOut <= '0;
            Valid    <= 1'b0;
        end else begin
            Ibb      <= fold_i_s;
            Qbb      <= fold_q_s;
            PhaseOut <= phase_s;
            Valid    <= en_d_r;
        end
    end

endmodule

// File: tb/tb_zigbee_phase_to_iq.sv
module tb_zigbee_phase_to_iq;

    logic              Clk;
    logic              Rst_n;
    logic              En;
    logic              LoadPhase;
    logic [5:0]        PhaseIn;
    logic [9:0]        Dphase;
    logic signed [4:0] Ibb;
    logic signed [4:0] Qbb;
    logic [5:0]        PhaseOut;
    logic              Valid;

    int checks;
    int failures;

    zigbee_phase_to_iq dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .En        (En),
        .LoadPhase (LoadPhase),
        .PhaseIn   (PhaseIn),
        .Dphase    (Dphase),
        .Ibb       (Ibb),
        .Qbb       (Qbb),
        .PhaseOut  (PhaseOut),
        .Valid     (Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int rnd_away(real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic int model_i(int p);
        return rnd_away(15.0 * $cos(real'(p) * 5.625 * 3.14159265358979 / 180.0));
    endfunction

    function automatic int model_q(int p);
        return rnd_away(15.0 * $sin(real'(p) * 5.625 * 3.14159265358979 / 180.0));
    endfunction

    task automatic test_reset();
        Rst_n = 1'b0; En = 1'b0; LoadPhase = 1'b0; PhaseIn = 6'd0; Dphase = 10'd0;
        step(); step();
        checks++;
        if (Ibb !== 5'sd0 || Qbb !== 5'sd0) begin
            failures++;
            $display("FAIL reset_iq: got I=%0d Q=%0d expected 0 0", Ibb, Qbb);
        end
        checks++;
        if (PhaseOut !== 6'd0 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_phase_valid: got phase=%0d valid=%b expected 0 0", PhaseOut, Valid);
        end
        Rst_n = 1'b1;
        step();
        checks++;
        if (Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid: got %b expected 0", Valid);
        end
    endtask

    task automatic test_load();
        int ph [4] = '{0, 16, 8, 40};
        int ei [4] = '{15, 0, 11, -11};
        int eq [4] = '{0, 15, 11, -11};
        for (int n = 0; n < 4; n++) begin
            LoadPhase = 1'b1; PhaseIn = 6'(ph[n]);
            step();
            LoadPhase = 1'b0;
            step();
            checks++;
            if (int'(Ibb) !== ei[n] || int'(Qbb) !== eq[n]) begin
                failures++;
                $display("FAIL load_iq p=%0d: got I=%0d Q=%0d expected %0d %0d", ph[n], Ibb, Qbb, ei[n], eq[n]);
            end
            checks++;
            if (int'(PhaseOut) !== ph[n] || Valid !== 1'b1) begin
                failures++;
                $display("FAIL load_phase p=%0d: got phase=%0d valid=%b expected %0d 1", ph[n], PhaseOut, Valid, ph[n]);
            end
        end
    endtask

    task automatic test_sweep();
        int ep;
        LoadPhase = 1'b1; PhaseIn = 6'd0;
        step();
        LoadPhase = 1'b0; En = 1'b1; Dphase = 10'd16;
        for (int n = 0; n < 65; n++) begin
            step();
            ep = n % 64;
            checks++;
            if (int'(PhaseOut) !== ep || Valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_phase n=%0d: got phase=%0d valid=%b expected %0d 1", n, PhaseOut, Valid, ep);
            end
            checks++;
            if (int'(Ibb) !== model_i(ep) || int'(Qbb) !== model_q(ep)) begin
                failures++;
                $display("FAIL sweep_iq p=%0d: got I=%0d Q=%0d expected %0d %0d", ep, Ibb, Qbb, model_i(ep), model_q(ep));
            end
        end
        En = 1'b0;
    endtask

    task automatic test_wrap();
        int ep [2] = '{63, 62};
        int ei [2] = '{15, 15};
        int eq [2] = '{-1, -3};
        LoadPhase = 1'b1; PhaseIn = 6'd0;
        step();
        LoadPhase = 1'b0; En = 1'b1; Dphase = 10'h3F0;
        step();  // sample of the loaded phase 0
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (int'(PhaseOut) !== ep[n] || int'(Ibb) !== ei[n] || int'(Qbb) !== eq[n]) begin
                failures++;
                $display("FAIL wrap n=%0d: got phase=%0d I=%0d Q=%0d expected %0d %0d %0d",
                         n, PhaseOut, Ibb, Qbb, ep[n], ei[n], eq[n]);
            end
        end
        En = 1'b0;
    endtask

    task automatic test_frac_and_load_priority();
        int ep [8] = '{0, 0, 0, 0, 1, 20, 20, 20};
        LoadPhase = 1'b1; PhaseIn = 6'd0;
        step();
        LoadPhase = 1'b0; En = 1'b1; Dphase = 10'd4;
        for (int n = 0; n < 8; n++) begin
            if (n == 4) begin
                LoadPhase = 1'b1; PhaseIn = 6'd20;
            end else begin
                LoadPhase = 1'b0;
            end
            step();
            checks++;
            if (int'(PhaseOut) !== ep[n] || Valid !== 1'b1) begin
                failures++;
                $display("FAIL frac n=%0d: got phase=%0d valid=%b expected %0d 1", n, PhaseOut, Valid, ep[n]);
            end
        end
        LoadPhase = 1'b0;
    endtask

    task automatic test_hold();
        // Accumulator holds phase 20 (+ fraction) from the previous scenario.
        En = 1'b0;
        step();
        checks++;
        if (PhaseOut !== 6'd20 || Valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_first: got phase=%0d valid=%b expected 20 1", PhaseOut, Valid);
        end
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (PhaseOut !== 6'd20 || Valid !== 1'b0 || Ibb !== -5'sd6 || Qbb !== 5'sd14) begin
                failures++;
                $display("FAIL hold n=%0d: got phase=%0d valid=%b I=%0d Q=%0d expected 20 0 -6 14",
                         n, PhaseOut, Valid, Ibb, Qbb);
            end
        end
    endtask

    task automatic test_midreset();
        LoadPhase = 1'b1; PhaseIn = 6'd0;
        step();
        LoadPhase = 1'b0; En = 1'b1; Dphase = 10'd16;
        repeat (5) step();
        Rst_n = 1'b0;
        step();
        checks++;
        if (Ibb !== 5'sd0 || Qbb !== 5'sd0 || PhaseOut !== 6'd0 || Valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset: got I=%0d Q=%0d phase=%0d valid=%b expected 0 0 0 0",
                     Ibb, Qbb, PhaseOut, Valid);
        end
        Rst_n = 1'b1; En = 1'b0;
        step();
        checks++;
        if (Valid !== 1'b0 || PhaseOut !== 6'd0 || Ibb !== 5'sd15) begin
            failures++;
            $display("FAIL midreset_release: got valid=%b phase=%0d I=%0d expected 0 0 15",
                     Valid, PhaseOut, Ibb);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_load();
        test_sweep();
        test_wrap();
        test_frac_and_load_priority();
        test_hold();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zigbee_phase_to_iq.md
Name: zigbee_phase_to_iq

Overview:
- Transmit-side counterpart of the CORDIC phase detector: converts a phase word into baseband I/Q samples (Ibb, Qbb).
- A phase accumulator with a fractional part, followed by a registered quarter-wave cosine LUT.
- Used for O-QPSK/half-sine phase generation in the modulator and as a loopback stimulus source for zigbee_cordic_top.
- Phase LSB = 5.625° (64 steps per turn). Amplitude matches the receive-side convention (15).

Parameters:
- IQ_SIZE, 5, signed width of Ibb/Qbb.
- W_SIZE, 6, integer phase width (2^W_SIZE steps per turn).
- ACC_FRAC, 4, fractional accumulator bits below the phase LSB.
- AMPLITUDE, 15, peak magnitude of Ibb/Qbb. Must be ≤ 2^(IQ_SIZE-1)-1.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  synchronous active-low reset.
- En  in  1  sample strobe; advances the accumulator and marks the output sample valid.
- LoadPhase  in  1  loads absolute phase from PhaseIn.
- PhaseIn  in  W_SIZE  absolute phase, unsigned, LSB = 5.625°.
- Dphase  in  W_SIZE+ACC_FRAC  signed phase increment per En, LSB = 5.625°/2^ACC_FRAC.
- Ibb  out  IQ_SIZE  signed in-phase sample.
- Qbb  out  IQ_SIZE  signed quadrature sample.
- PhaseOut  out  W_SIZE  phase used for the current Ibb/Qbb.
- Valid  out  1  Ibb/Qbb/PhaseOut carry a new sample.

Behaviour:
- One clock (Clk); reset is synchronous and active-low (Rst_n). All state changes on the rising edge of Clk.
- Reset (Rst_n=0 at an edge):
  - Accumulator Acc = 0; Ibb = 0, Qbb = 0, PhaseOut = 0, Valid = 0.
  - Mid-operation reset discards all in-flight samples.
  - After release, Valid stays 0 until an En propagates.
- Accumulator (stage 0): Acc is unsigned, W_SIZE+ACC_FRAC = 10 bits, arithmetic modulo 2^10. At each edge:
  - LoadPhase=1: Acc <= {PhaseIn, ACC_FRAC'b0}. This happens regardless of En. When LoadPhase and En are both 1, the load wins and Dphase is ignored that cycle.
  - else if En=1: Acc <= Acc + sign-extended Dphase. Wrap is natural in both directions, e.g. 0 + (-16) = 1008.
  - else: Acc holds.
- Phase extraction: p = Acc[9:4], truncated with no rounding. Quadrant q = p[5:4], index k = p[3:0].
- LUT: C[k] = round-half-away(AMPLITUDE·cos(k·5.625°)), k = 0..16:
  - 15,15,15,14,14,13,12,12,11,10,8,7,6,4,3,1,0.
- Quadrant fold:
  - q0: I=C[k], Q=C[16-k].
  - q1: I=-C[16-k], Q=C[k].
  - q2: I=-C[k], Q=-C[16-k].
  - q3: I=C[16-k], Q=-C[k].
  - Negation never overflows because |C| ≤ 15.
- Output (stage 1): each edge registers Ibb, Qbb and PhaseOut = p from the current Acc (pipeline always advances).
  - Valid <= En_d, where En_d is En (or LoadPhase) registered at the previous edge.
- Latency: with En or LoadPhase sampled at edge N, Acc updates at N. Ibb/Qbb/PhaseOut/Valid reflect that Acc after edge N+1.
  - Continuous En gives one sample per clock; throughput is 1.
- En=0: Acc frozen. Outputs keep recomputing from the unchanged Acc (same values). Valid drops one cycle later.
- Loopback invariant: feeding Ibb/Qbb into zigbee_cordic_top must give Wout within ±1 LSB of PhaseOut (mod 64).

Decomposition:
- Package zigbee_iq_pkg:
  - Constants IQ_SIZE, W_SIZE, AMPLITUDE, PHASE_LSB_DEG = 5.625.
  - Typedefs iq_t (signed IQ_SIZE) and phase_t (unsigned W_SIZE).
  - Constant array COS_LUT[0:16].
  - This package is shared with the CORDIC block and its benches.
- One combinational sub-module, zigbee_quarter_fold: inputs p; outputs I, Q (LUT plus quadrant fold). The top module holds the accumulator, pipeline registers and Valid.

Test Plan:
- Reset, then LoadPhase=1, PhaseIn=0 → after 2 edges: Ibb=15, Qbb=0, PhaseOut=0, Valid=1.
- LoadPhase with PhaseIn=16, 8, 40 → (I,Q) = (0,15), (11,11), (-11,-11) respectively, each 2 edges after load.
- Load 0, then En=1, Dphase=16 for 65 cycles → PhaseOut steps 0,1,…,63,0 one per clock; Valid stays 1; Ibb/Qbb match the fold table at every step.
- Load 0, then En=1, Dphase=-16 → PhaseOut=63, Ibb=15, Qbb=-1. Next sample: PhaseOut=62, Ibb=15, Qbb=-3 (wrap below zero).
- Dphase=4 with En held for 8 cycles → PhaseOut advances by 1 every 4 samples. Simultaneously assert LoadPhase with En at cycle 5: the load wins and PhaseIn appears 2 edges later.
- Assert Rst_n=0 for one edge mid-sweep → next edge: Ibb=Qbb=PhaseOut=0, Valid=0. Random loopback through zigbee_cordic_top: |Wout-PhaseOut| ≤ 1 LSB mod 64.
